// File: rtl/timer_pkg.sv
// Shared constants and helpers for the tick timer controller.
package timer_pkg;

  // Command FSM encoding
  localparam logic [0:0] CFG_IDLE  = 1'b0;
  localparam logic [0:0] CFG_APPLY = 1'b1;

  // Channel FSM encoding
  localparam logic [0:0] CH_IDLE = 1'b0;
  localparam logic [0:0] CH_RUN  = 1'b1;

  // Channel run modes
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Width of the channel-select field for a given channel count
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tick_timer_ctrl_if.sv
// Valid/ready configuration bus of the tick timer controller.
interface tick_timer_ctrl_if
  import timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  localparam int CH_W = ch_width(CHANNELS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_start;
  logic             cfg_mode;
  logic [CNT_W-1:0] cfg_period;

  // Command issuer side
  modport master (
    output cfg_valid, cfg_ch, cfg_start, cfg_mode, cfg_period,
    input  cfg_ready
  );

  // Timer controller side
  modport slave (
    input  cfg_valid, cfg_ch, cfg_start, cfg_mode, cfg_period,
    output cfg_ready
  );
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: counter, latched mode/period and run state.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic             mode,
  output logic             busy,
  output logic             expired
);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             mode_r;
  logic             expired_r;

  // Channel state: commands take priority over a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= CH_IDLE;
      cnt_r     <= CNT_ZERO;
      period_r  <= CNT_ZERO;
      mode_r    <= MODE_ONESHOT;
      expired_r <= 1'b0;
    end else begin
      expired_r <= 1'b0;
      if (stop) begin
        state_r <= CH_IDLE;
        cnt_r   <= CNT_ZERO;
      end else if (load) begin
        state_r  <= CH_RUN;
        cnt_r    <= period;
        period_r <= period;
        mode_r   <= mode;
      end else if (tick) begin
        case (state_r)
          CH_RUN: begin
            if (cnt_r == CNT_ONE) begin
              expired_r <= 1'b1;
              if (mode_r == MODE_PERIODIC) begin
                cnt_r <= period_r;
              end else begin
                cnt_r   <= CNT_ZERO;
                state_r <= CH_IDLE;
              end
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          default: begin
            cnt_r <= cnt_r;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign busy    = (state_r == CH_RUN);
  assign expired = expired_r;
endmodule

// File: rtl/tick_timer_ctrl.sv
// Multi-channel timer controller sharing one free-running prescaler.
module tick_timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50_000,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tick_timer_ctrl_if.slave    cfg,
  output logic                tick,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expired
);
  localparam int CH_W  = ch_width(CHANNELS);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_r;
  logic [0:0]       cfg_state_r;
  logic [CH_W-1:0]  cap_ch_r;
  logic             cap_start_r;
  logic             cap_mode_r;
  logic [CNT_W-1:0] cap_period_r;
  logic             apply_s;
  logic             start_ok_s;

  // Free-running prescaler, never touched by commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (pre_cnt_r == PRE_MAX) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1);
    end
  end

  assign tick = (pre_cnt_r == PRE_MAX);

  // Command FSM: capture in IDLE, apply for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_state_r  <= CFG_IDLE;
      cap_ch_r     <= {CH_W{1'b0}};
      cap_start_r  <= 1'b0;
      cap_mode_r   <= MODE_ONESHOT;
      cap_period_r <= {CNT_W{1'b0}};
    end else begin
      case (cfg_state_r)
        CFG_IDLE: begin
          if (cfg.cfg_valid) begin
            cap_ch_r     <= cfg.cfg_ch;
            cap_start_r  <= cfg.cfg_start;
            cap_mode_r   <= cfg.cfg_mode;
            cap_period_r <= cfg.cfg_period;
            cfg_state_r  <= CFG_APPLY;
          end else begin
            cfg_state_r <= CFG_IDLE;
          end
        end
        CFG_APPLY: begin
          cfg_state_r <= CFG_IDLE;
        end
        default: begin
          cfg_state_r <= CFG_IDLE;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = (cfg_state_r == CFG_IDLE);

  // A start with a zero period is treated as a stop
  always_comb begin
    apply_s    = (cfg_state_r == CFG_APPLY);
    start_ok_s = cap_start_r && (cap_period_r != {CNT_W{1'b0}});
  end

  // Channel select values beyond CHANNELS-1 match no instance and are dropped
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit_s;
    assign hit_s = apply_s && (cap_ch_r == CH_W'(i));

    timer_channel #(.CNT_W(CNT_W)) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .load    (hit_s && start_ok_s),
      .stop    (hit_s && !start_ok_s),
      .period  (cap_period_r),
      .mode    (cap_mode_r),
      .busy    (busy[i]),
      .expired (expired[i])
    );
  end
endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl: expiry edges are predicted arithmetically
// from the apply edge, the period and the tick rate, and checked by a monitor.
module tb_tick_timer_ctrl;
  localparam int P     = 4;
  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int HORIZ = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] expired;

  always #5 clk = ~clk;

  tick_timer_ctrl_if #(.CHANNELS(NCH), .CNT_W(CW)) cfg_bus ();

  tick_timer_ctrl #(.PRESCALE(P), .CHANNELS(NCH), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (cfg_bus),
    .tick    (tick),
    .busy    (busy),
    .expired (expired)
  );

  // Edges since the last reset release; edge n is the n-th rising edge
  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Reference state: expected expiry edges per channel, busy window, ready dip
  int exp_q[NCH][$];
  int busy_from[NCH];
  int busy_to[NCH];
  int ready_low_n = -1;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, expv, edge_cnt, $time);
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      busy_from[c] = 0;
      busy_to[c] = 0;
    end
    ready_low_n = -1;
  endtask

  // A command applied at edge e: the n-th tick strictly after e is tick
  // number floor(e/P)+n, which lands on edge (floor(e/P)+n)*P.
  task automatic apply_model(input int ch, input bit start, input bit mode, input int per, input int e);
    int first;
    exp_q[ch].delete();
    if (start && per != 0) begin
      first = (e / P + per) * P;
      busy_from[ch] = e;
      if (mode) begin
        for (int x = first; x < HORIZ; x += per * P) exp_q[ch].push_back(x);
        busy_to[ch] = 32'h7fff_ffff;
      end else begin
        exp_q[ch].push_back(first);
        busy_to[ch] = first;
      end
    end else begin
      busy_to[ch] = e;
    end
  endtask

  // Monitor: compares every output once per cycle, at the falling edge
  always @(negedge clk) begin
    int n;
    bit e;
    if (!rst_n) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_expired", int'(expired), 0);
      chk("rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);
      chk("rst_tick", int'(tick), 0);
    end else begin
      n = edge_cnt;
      chk("tick", int'(tick), int'(n % P == P - 1));
      chk("cfg_ready", int'(cfg_bus.cfg_ready), int'(n != ready_low_n));
      for (int c = 0; c < NCH; c++) begin
        while (exp_q[c].size() > 0 && exp_q[c][0] < n) begin
          chk($sformatf("missed_expiry_ch%0d", c), n, exp_q[c][0]);
          void'(exp_q[c].pop_front());
        end
        e = (exp_q[c].size() > 0 && exp_q[c][0] == n);
        if (e) void'(exp_q[c].pop_front());
        chk($sformatf("expired_ch%0d", c), int'(expired[c]), int'(e));
        chk($sformatf("busy_ch%0d", c), int'(busy[c]), int'(n >= busy_from[c] && n < busy_to[c]));
      end
    end
  end

  // Issue one command; with abort set, reset hits while it sits in the apply state
  task automatic send_cmd(input int ch, input bit start, input bit mode, input int per, input bit abort);
    int m;
    @(negedge clk);
    m = edge_cnt;
    ready_low_n = m + 1;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_ch     = 2'(ch);
    cfg_bus.cfg_start  = start;
    cfg_bus.cfg_mode   = mode;
    cfg_bus.cfg_period = 8'(per);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    #1;
    if (abort) begin
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("async_rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_expired", int'(expired), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      apply_model(ch, start, mode, per, m + 2);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Wait so that the next send_cmd applies on an edge with edge % P == r
  task automatic align_apply(input int r);
    for (int k = 0; k < 2 * P; k++) begin
      if ((edge_cnt + 3) % P == r) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_ch     = 2'd0;
    cfg_bus.cfg_start  = 1'b0;
    cfg_bus.cfg_mode   = 1'b0;
    cfg_bus.cfg_period = 8'd0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: tick pattern only
    idle(16);

    // One-shot ch0 period 3, then quiet
    send_cmd(0, 1'b1, 1'b0, 3, 1'b0);
    idle(40);

    // Periodic ch2 period 2, stopped after three expiries
    send_cmd(2, 1'b1, 1'b1, 2, 1'b0);
    idle(26);
    send_cmd(2, 1'b0, 1'b1, 2, 1'b0);
    idle(20);

    // ch3 period 1 expires on the very tick that ch1's apply swallows
    align_apply(P - 2);
    send_cmd(3, 1'b1, 1'b0, 1, 1'b0);
    send_cmd(1, 1'b1, 1'b0, 1, 1'b0);
    idle(12);

    // Restart ch0 mid-count, and a zero-period start on idle ch1
    send_cmd(0, 1'b1, 1'b0, 4, 1'b0);
    idle(7);
    send_cmd(0, 1'b1, 1'b0, 5, 1'b0);
    send_cmd(1, 1'b1, 1'b1, 0, 1'b0);
    idle(30);

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 10));
      send_cmd($urandom_range(0, NCH - 1), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'b0);
    end
    idle(40);

    // Reset mid-count, asynchronous to the clock
    send_cmd(0, 1'b1, 1'b1, 2, 1'b0);
    send_cmd(3, 1'b1, 1'b0, 6, 1'b0);
    idle(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_busy_mid", int'(busy), 0);
    chk("async_rst_ready_mid", int'(cfg_bus.cfg_ready), 1);
    idle(2);
    rst_n = 1'b1;
    idle(12);

    // Reset while a command is waiting in the apply state
    send_cmd(1, 1'b1, 1'b1, 1, 1'b0);
    idle(3);
    send_cmd(2, 1'b1, 1'b1, 1, 1'b1);
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
